// File: rtl/w_col_skew_feeder.sv
// w_col_skew_feeder
//   Walks a weight tile one k-column at a time. For each column it asks the
//   upstream loader for column k (start_k/k_idx), waits for col_valid, latches
//   the M words of that column (col_accept), then injects the column into a
//   skew pipeline that feeds the PE rows.
//
//   Build option WFEED_SKEW_EN:
//     defined   -> row r of a column reaches the PE array r cycles after row 0
//     undefined -> every row of a column reaches the PE array in the same beat
//
//   Ports
//     clk, rst     clock, synchronous active-high reset
//     run, k_len   start pulse and column count (0..KMAX), sampled on run
//     busy, done   loop in progress / one-cycle completion pulse
//     start_k      one-cycle request for column k_idx
//     k_idx        requested column, stable until col_accept
//     col_valid    column k_idx present on W_tile_flat
//     col_accept   one-cycle pulse consuming the column
//     W_tile_flat  tile, word (r,k) at bit (r*KMAX+k)*DATA_W
//     pe_ready     PE array accepting; low freezes the skew pipeline
//     pe_w_valid   per-row weight valid
//     pe_w_data    per-row weight, row r at [r*DATA_W +: DATA_W]
module w_col_skew_feeder #(
    parameter int M      = 8,
    parameter int KMAX   = 1024,
    parameter int DATA_W = 32,
    parameter int K_W    = $clog2(KMAX)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic [K_W:0]               k_len,
    output logic                       busy,
    output logic                       done,
    output logic                       start_k,
    output logic [K_W-1:0]             k_idx,
    input  logic                       col_valid,
    output logic                       col_accept,
    input  logic [M*KMAX*DATA_W-1:0]   W_tile_flat,
    input  logic                       pe_ready,
    output logic [M-1:0]               pe_w_valid,
    output logic [M*DATA_W-1:0]        pe_w_data
);

`ifdef WFEED_SKEW_EN
    localparam int STAGES = M;
`else
    localparam int STAGES = 1;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, INJ, DRAIN} state_t;

    state_t state, state_nxt;

    // k is one bit wider than k_idx so k_len == KMAX terminates cleanly
    logic [K_W:0]                          k, k_nxt, klen_q;
    logic [M-1:0][DATA_W-1:0]              col_buf, col_word;
    logic [M-1:0][KMAX-1:0][DATA_W-1:0]    tile;
    logic [STAGES-1:0]                     vld_pipe;
    logic [STAGES-1:0][M-1:0][DATA_W-1:0]  data_pipe;
    logic [M-1:0]                          row_vld;
    logic [M-1:0][DATA_W-1:0]              row_out;
    logic                                  any_vld, inject;

    assign tile    = W_tile_flat;
    assign k_idx   = k[K_W-1:0];
    assign k_nxt   = k + 1'b1;
    assign any_vld = |vld_pipe;

    always_comb begin
        for (int r = 0; r < M; r++) col_word[r] = tile[r][k_idx];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (run) state_nxt = (k_len == '0) ? DRAIN : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (col_valid) state_nxt = CAPT;
            CAPT:    state_nxt = INJ;
            INJ:     if (pe_ready) state_nxt = (k_nxt < klen_q) ? ISSUE : DRAIN;
            DRAIN:   if (!any_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Gated by rst so control outputs are quiet for every cycle rst is high,
    // including the first one before the state register has been cleared.
    always_comb begin
        start_k    = 1'b0;
        col_accept = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        inject     = 1'b0;
        if (!rst) begin
            start_k    = (state == ISSUE);
            col_accept = (state == CAPT);
            inject     = (state == INJ) && pe_ready;
            done       = (state == DRAIN) && !any_vld;
            busy       = (state != IDLE) && !done;
        end
    end

    // ---------------- loop counter and column buffer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            k       <= '0;
            klen_q  <= '0;
            col_buf <= '0;
        end else begin
            if (state == IDLE && run) begin
                k      <= '0;
                klen_q <= k_len;
            end
            if (state == CAPT) col_buf <= col_word;
            if (inject)        k       <= k_nxt;
        end
    end

    // ---------------- skew pipeline ----------------
    // Stage s holds the column injected s+1 beats ago; row r is tapped from
    // stage r, which gives the diagonal wavefront. The whole pipe advances
    // only when pe_ready is high, so a stall neither drops nor repeats beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else if (pe_ready) begin
            vld_pipe[0] <= inject;
            if (inject) data_pipe[0] <= col_buf;
            for (int s = 1; s < STAGES; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                data_pipe[s] <= data_pipe[s-1];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < M; r++) begin
`ifdef WFEED_SKEW_EN
            row_vld[r] = vld_pipe[r];
            row_out[r] = data_pipe[r][r];
`else
            row_vld[r] = vld_pipe[0];
            row_out[r] = data_pipe[0][r];
`endif
        end
    end

    assign pe_w_valid = rst ? '0 : row_vld;
    assign pe_w_data  = rst ? '0 : row_out;

endmodule

// File: tb/tb_w_col_skew_feeder.sv
// Self-checking bench for w_col_skew_feeder. A monitor process plays the
// upstream loader (answers start_k after col_lat cycles) and keeps a per-row
// scoreboard: on each col_accept the column's words are queued with their
// due cycle, and every PE beat pops and compares the head of its row queue.
module tb_w_col_skew_feeder;
    localparam int M      = 8;
    localparam int KMAX   = 1024;
    localparam int DATA_W = 32;
    localparam int K_W    = 10;
    localparam int CW     = M*DATA_W;
`ifdef WFEED_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    logic clk = 1'b0;
    logic rst, run, col_valid, pe_ready;
    logic [K_W:0] k_len;
    logic busy, done, start_k, col_accept;
    logic [K_W-1:0] k_idx;
    logic [M-1:0][KMAX-1:0][DATA_W-1:0] tile;
    logic [M-1:0] pe_w_valid;
    logic [M*DATA_W-1:0] pe_w_data;

    always #5 clk = ~clk;

    w_col_skew_feeder #(.M(M), .KMAX(KMAX), .DATA_W(DATA_W), .K_W(K_W)) dut (
        .clk(clk), .rst(rst), .run(run), .k_len(k_len), .busy(busy), .done(done),
        .start_k(start_k), .k_idx(k_idx), .col_valid(col_valid), .col_accept(col_accept),
        .W_tile_flat(tile), .pe_ready(pe_ready), .pe_w_valid(pe_w_valid), .pe_w_data(pe_w_data)
    );

    typedef struct { logic [DATA_W-1:0] w; int due; } beat_t;
    beat_t rowq [M][$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int beats = 0, n_start = 0, n_acc = 0, done_cnt = 0;
    int col_lat = 3;
    bit chk_time = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] wexp(input int r, input int k);
        return 32'hA000_0000 + (r << 16) + k;
    endfunction

    // ---------------- upstream model + scoreboard monitor ----------------
    initial begin
        int exp_k, pend_k, dly, qsz;
        bit pend, prev_ready, prev_rst;
        logic [M-1:0] prev_v;
        logic [CW-1:0] prev_d;
        logic [M-1:0] all_v;
        beat_t e;
        all_v = '1;
        exp_k = 0; pend = 1'b0; pend_k = 0; dly = 0;
        prev_ready = 1'b1; prev_rst = 1'b1; prev_v = '0; prev_d = '0;
        col_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                col_valid = 1'b0;
                pend = 1'b0;
                exp_k = 0;
                for (int r = 0; r < M; r++) rowq[r].delete();
                prev_rst = 1'b1;
            end else begin
                for (int r = 0; r < M; r++) begin
                    if (pe_w_valid[r] && pe_ready) begin
                        beats++;
                        if (rowq[r].size() == 0) chk("beat_unexpected", 1, 0);
                        else begin
                            e = rowq[r].pop_front();
                            chk("beat_data", pe_w_data[r*DATA_W +: DATA_W], e.w);
                            if (e.due >= 0) chk("beat_cycle", cyc, e.due);
                        end
                    end
                end
`ifndef WFEED_SKEW_EN
                if (|pe_w_valid) chk("rows_together", pe_w_valid, all_v);
`endif
                if (!prev_ready && !prev_rst) begin
                    chk("stall_hold_valid", pe_w_valid, prev_v);
                    chk("stall_hold_data", pe_w_data, prev_d);
                end
                if (done) begin
                    done_cnt++;
                    qsz = 0;
                    for (int r = 0; r < M; r++) qsz += rowq[r].size();
                    chk("busy_low_at_done", busy, 0);
                    chk("beats_before_done", qsz, 0);
                    exp_k = 0;
                end
                if (start_k) begin
                    n_start++;
                    chk("k_order", k_idx, exp_k);
                    exp_k++;
                    pend = 1'b1; pend_k = k_idx; dly = col_lat;
                end else if (pend) begin
                    if (dly > 1) dly--;
                    else begin col_valid = 1'b1; pend = 1'b0; end
                end
                if (col_accept) begin
                    n_acc++;
                    chk("k_idx_hold", k_idx, pend_k);
                    col_valid = 1'b0;
                    for (int r = 0; r < M; r++) begin
                        e.w = wexp(r, pend_k);
                        e.due = chk_time ? cyc + 2 + SKEW*r : -1;
                        rowq[r].push_back(e);
                    end
                end
                prev_rst = 1'b0;
            end
            prev_ready = pe_ready; prev_v = pe_w_valid; prev_d = pe_w_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_run(input int kl);
        k_len = (K_W+1)'(kl);
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int n = 0;
        while (done_cnt == d0 && n < limit) begin @(posedge clk); #1; n++; end
        chk("done_within_budget", done_cnt != d0, 1);
    endtask

    task automatic single_col(input string tag);
        int s0, a0, b0, d0;
        s0 = n_start; a0 = n_acc; b0 = beats; d0 = done_cnt;
        col_lat = 3; chk_time = 1'b1;
        pulse_run(1);
        wait_done(d0, 200);
        repeat (4) begin @(posedge clk); #1; end
        chk({tag, "_starts"}, n_start - s0, 1);
        chk({tag, "_accepts"}, n_acc - a0, 1);
        chk({tag, "_beats"}, beats - b0, M);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int s0, b0, d0, n;
        rst = 1'b1; run = 1'b0; k_len = '0; pe_ready = 1'b1;
        for (int r = 0; r < M; r++)
            for (int k = 0; k < KMAX; k++) tile[r][k] = wexp(r, k);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_start_k", start_k, 0); chk("rst_col_accept", col_accept, 0);
        chk("rst_pe_w_valid", pe_w_valid, 0); chk("rst_pe_w_data", pe_w_data, 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // single column, loader answers 3 cycles after start_k
        single_col("k1");

        // three columns back to back
        s0 = n_start; b0 = beats; d0 = done_cnt; col_lat = 2;
        pulse_run(3);
        wait_done(d0, 400);
        chk("k3_starts", n_start - s0, 3);
        chk("k3_beats", beats - b0, 3*M);

        // 4-cycle PE stall in the middle of a two-column stream
        s0 = n_start; b0 = beats; d0 = done_cnt; col_lat = 1; chk_time = 1'b0;
        pulse_run(2);
        n = 0;
        while (beats - b0 < 3 && n < 200) begin @(posedge clk); #1; n++; end
        chk("stall_first_beats", beats - b0 >= 3, 1);
        pe_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        pe_ready = 1'b1;
        wait_done(d0, 400);
        chk_time = 1'b1;
        chk("stall_beats", beats - b0, 2*M);
        chk("stall_starts", n_start - s0, 2);

        // k_len = 0: done next cycle, no column request
        s0 = n_start; d0 = done_cnt;
        pulse_run(0);
        @(negedge clk);
        chk("zero_done_next", done, 1);
        chk("zero_busy", busy, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("zero_done_once", done_cnt - d0, 1);
        chk("zero_no_start", n_start - s0, 0);

        // run pulsed while busy is ignored
        s0 = n_start; b0 = beats; d0 = done_cnt; col_lat = 4;
        pulse_run(2);
        repeat (5) begin @(posedge clk); #1; end
        chk("busy_mid_loop", busy, 1);
        pulse_run(1);
        wait_done(d0, 400);
        repeat (6) begin @(posedge clk); #1; end
        chk("ignored_run_starts", n_start - s0, 2);
        chk("ignored_run_beats", beats - b0, 2*M);
        chk("ignored_run_done", done_cnt - d0, 1);

        // reset while waiting for column 1 aborts without done
        s0 = n_start; d0 = done_cnt; col_lat = 8;
        pulse_run(2);
        n = 0;
        while (n_start - s0 < 2 && n < 200) begin @(posedge clk); #1; n++; end
        chk("abort_reached_k1", n_start - s0, 2);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0); chk("abort_done", done, 0);
        chk("abort_start_k", start_k, 0); chk("abort_col_accept", col_accept, 0);
        chk("abort_pe_w_valid", pe_w_valid, 0); chk("abort_pe_w_data", pe_w_data, 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle", busy, 0);

        single_col("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
